sgd_x_mem_writeback: RTL and testbench

Drains the per-engine updated-model FIFOs (dma_clk side of the x write-back path) into a single 512-bit DMA write stream, one epoch at a time. It restores memory order across engines, issues one send-back command (start/addr/length) per epoch, and throttles on the DMA almost-full back-pressure. It sits directly downstream of the x-to-memory FIFO stage and directly upstream of the DMA write engine.

---
 rtl/sgd_pkg.sv | 25 ++
 rtl/sgd_x_wb_geometry.sv | 41 ++++
 rtl/sgd_x_mem_writeback.sv | 172 +++++++++++++++++
 tb/tb_sgd_x_mem_writeback.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared constants, FSM states and error codes for the x write-back path.
// Engine count and bank depth must stay powers of two.
package sgd_pkg;

    localparam int ENGINE_NUM        = 8;
    localparam int ENGINE_BITS       = $clog2(ENGINE_NUM);
    localparam int LINES_PER_BANK    = 4;
    localparam int LPB_BITS          = $clog2(LINES_PER_BANK);
    // log2 of features held by one engine per chunk (4 lines x 16 floats)
    localparam int NUM_BITS_PER_BANK = 6;
    localparam int LINE_W            = 512;
    localparam int LINE_BYTES_BITS   = 6;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PREP = 4'd1,
        ST_CMD  = 4'd2,
        ST_DATA = 4'd3,
        ST_DONE = 4'd4
    } wb_state_e;

    localparam logic [3:0] ERR_NONE     = 4'b0000;
    localparam logic [3:0] ERR_DIM_ZERO = 4'b0001;

endpackage

// File: rtl/sgd_x_wb_geometry.sv
// Per-epoch geometry: lines to drain and byte length of the send-back command.
// Registered so the divide-by-shift settles during the single PREP cycle.
module sgd_x_wb_geometry
    import sgd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dimension_i,
    output logic [31:0] lines_o,
    output logic [31:0] length_o
);

    localparam int CHUNK_SHIFT = ENGINE_BITS + NUM_BITS_PER_BANK;
    localparam int LINE_SHIFT  = ENGINE_BITS + LPB_BITS;

    logic [32:0] sum_d;
    logic [32:0] chunks_d;
    logic [31:0] lines_d;
    logic [31:0] lines_q;
    logic [31:0] length_q;

    always_comb begin
        sum_d    = {1'b0, dimension_i} + 33'((1 << CHUNK_SHIFT) - 1);
        chunks_d = sum_d >> CHUNK_SHIFT;
        lines_d  = 32'(chunks_d << LINE_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q  <= '0;
            length_q <= '0;
        end else begin
            lines_q  <= lines_d;
            length_q <= lines_d << LINE_BYTES_BITS;
        end
    end

    assign lines_o  = lines_q;
    assign length_o = length_q;

endmodule

// File: rtl/sgd_x_mem_writeback.sv
// Drains engine FIFOs into one ordered 512-bit DMA write stream per epoch.
// X_WB_EPOCH_HISTORY_EN: each epoch lands at addr_model + k*length.
module sgd_x_mem_writeback
    import sgd_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         started,
    input  logic [63:0]                  addr_model,
    input  logic [31:0]                  dimension,
    input  logic [31:0]                  numEpochs,
    input  logic [ENGINE_NUM*LINE_W-1:0] x_to_mem_rd_data,
    input  logic [ENGINE_NUM-1:0]        x_to_mem_empty,
    output logic [ENGINE_NUM-1:0]        x_to_mem_rd_en,
    output logic                         x_data_send_back_start,
    output logic [63:0]                  x_data_send_back_addr,
    output logic [31:0]                  x_data_send_back_length,
    output logic [LINE_W-1:0]            x_data_out,
    output logic                         x_data_out_valid,
    input  logic                         x_data_out_almost_full,
    output logic                         writeback_done,
    output logic [31:0]                  state_counters_x_wb
);

    wb_state_e              state_q;
    logic                   started_q;
    logic [63:0]            addr_q;
    logic [63:0]            addr_cur_q;
    logic [31:0]            dim_q;
    logic [31:0]            nep_q;
    logic [31:0]            epoch_q;
    logic [3:0]             err_q;
    logic                   done_q;
    logic [LPB_BITS-1:0]    line_q;
    logic [ENGINE_BITS-1:0] eng_q;
    logic [31:0]            total_q;
    logic                   start_q;
    logic [63:0]            cmd_addr_q;
    logic [31:0]            cmd_len_q;
    logic                   rd_v_q;
    logic [ENGINE_BITS-1:0] sel_q;
    logic                   valid_q;
    logic [LINE_W-1:0]      data_q;

    logic [31:0]            geo_lines;
    logic [31:0]            geo_len;
    logic                   rd_any;
    logic [ENGINE_NUM-1:0]  rd_en_d;

    sgd_x_wb_geometry u_geo (
        .clk         (clk),
        .rst_n       (rst_n),
        .dimension_i (dim_q),
        .lines_o     (geo_lines),
        .length_o    (geo_len)
    );

    // Back-pressure goes straight into the strobe so the read stops this cycle.
    always_comb begin
        rd_en_d = '0;
        rd_any  = (state_q == ST_DATA) && !x_to_mem_empty[eng_q]
                  && !x_data_out_almost_full;
        if (rd_any) rd_en_d[eng_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            started_q  <= 1'b0;
            addr_q     <= '0;
            addr_cur_q <= '0;
            dim_q      <= '0;
            nep_q      <= '0;
            epoch_q    <= '0;
            err_q      <= ERR_NONE;
            done_q     <= 1'b0;
            line_q     <= '0;
            eng_q      <= '0;
            total_q    <= '0;
            start_q    <= 1'b0;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            rd_v_q     <= 1'b0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            started_q <= started;
            start_q   <= 1'b0;
            rd_v_q    <= rd_any;
            sel_q     <= eng_q;
            valid_q   <= rd_v_q;
            if (rd_v_q) data_q <= x_to_mem_rd_data[sel_q*LINE_W +: LINE_W];

            unique case (state_q)
                ST_IDLE: begin
                    if (started && !started_q) begin
                        addr_q  <= addr_model;
                        dim_q   <= dimension;
                        nep_q   <= numEpochs;
                        epoch_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= ERR_NONE;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    addr_cur_q <= addr_q;
                    line_q     <= '0;
                    eng_q      <= '0;
                    total_q    <= '0;
                    if (dim_q == 32'd0) begin
                        err_q   <= ERR_DIM_ZERO;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (nep_q == 32'd0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!x_to_mem_empty[0]) begin
                        start_q    <= 1'b1;
                        cmd_addr_q <= addr_cur_q;
                        cmd_len_q  <= geo_len;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rd_any) begin
                        line_q <= line_q + 1'b1;
                        if (line_q == LPB_BITS'(LINES_PER_BANK - 1)) begin
                            line_q <= '0;
                            eng_q  <= eng_q + 1'b1;
                        end
                        if (total_q == geo_lines - 32'd1) begin
                            total_q <= '0;
                            epoch_q <= epoch_q + 32'd1;
`ifdef X_WB_EPOCH_HISTORY_EN
                            addr_cur_q <= addr_cur_q + 64'(geo_len);
`endif
                            if (epoch_q + 32'd1 == nep_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                state_q <= ST_CMD;
                            end
                        end else begin
                            total_q <= total_q + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!started) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x_to_mem_rd_en          = rd_en_d;
    assign x_data_send_back_start  = start_q;
    assign x_data_send_back_addr   = cmd_addr_q;
    assign x_data_send_back_length = cmd_len_q;
    assign x_data_out              = data_q;
    assign x_data_out_valid        = valid_q;
    assign writeback_done          = done_q;
    assign state_counters_x_wb     = {epoch_q[15:0], err_q, 8'h00, state_q};

endmodule

// File: tb/tb_sgd_x_mem_writeback.sv
// Randomised bench for sgd_x_mem_writeback against a queue-based order model.
// Honours X_WB_EPOCH_HISTORY_EN when computing expected command addresses.
module tb_sgd_x_mem_writeback;
    import sgd_pkg::*;

    localparam int EN  = ENGINE_NUM;
    localparam int LPB = LINES_PER_BANK;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              started = 1'b0;
    logic [63:0]       addr_model = '0;
    logic [31:0]       dimension = '0;
    logic [31:0]       numEpochs = '0;
    logic [EN*512-1:0] rd_data;
    logic [EN-1:0]     empty = '1;
    logic [EN-1:0]     rd_en;
    logic              start;
    logic [63:0]       cmd_addr;
    logic [31:0]       cmd_len;
    logic [511:0]      x_data_out;
    logic              valid;
    logic              af = 1'b0;
    logic              done;
    logic [31:0]       sc;

    sgd_x_mem_writeback dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .started                 (started),
        .addr_model              (addr_model),
        .dimension               (dimension),
        .numEpochs               (numEpochs),
        .x_to_mem_rd_data        (rd_data),
        .x_to_mem_empty          (empty),
        .x_to_mem_rd_en          (rd_en),
        .x_data_send_back_start  (start),
        .x_data_send_back_addr   (cmd_addr),
        .x_data_send_back_length (cmd_len),
        .x_data_out              (x_data_out),
        .x_data_out_valid        (valid),
        .x_data_out_almost_full  (af),
        .writeback_done          (done),
        .state_counters_x_wb     (sc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int beats = 0;
    int starts = 0;
    int af_run = 0;
    bit rand_en = 1'b0;

    logic [511:0] fq [EN][$];
    logic [511:0] dout [EN];
    logic [EN-1:0] hold = '0;
    logic [511:0] exp_beats [$];
    logic [63:0]  ecmd_a [$];
    logic [31:0]  ecmd_l [$];

    task automatic check(input string n, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial for (int i = 0; i < EN; i++) dout[i] = '0;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < EN; i++) rd_data[i*512 +: 512] = dout[i];
    end

    // Standard (non-FWFT) FIFO models with registered empty flags
    always @(posedge clk) begin
        logic [511:0] t;
        for (int i = 0; i < EN; i++) begin
            if (rd_en[i]) begin
                check($sformatf("rd_nonempty%0d", i), empty[i], 1'b0);
                if (!empty[i]) begin
                    t = fq[i].pop_front();
                    dout[i] <= t;
                end
            end
        end
        for (int i = 0; i < EN; i++)
            empty[i] <= (fq[i].size() == 0) || hold[i];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                beats++;
                if (exp_beats.size() == 0) check("extra_beat", 1'b1, 1'b0);
                else check("beat", x_data_out, exp_beats.pop_front());
            end
            if (start) begin
                starts++;
                if (ecmd_a.size() == 0) check("extra_cmd", 1'b1, 1'b0);
                else begin
                    check("cmd_addr", cmd_addr, ecmd_a.pop_front());
                    check("cmd_len", cmd_len, ecmd_l.pop_front());
                end
            end
            af_run = af ? af_run + 1 : 0;
            if (af) check("af_rd_en", rd_en, '0);
            if (af_run >= 3) check("af_valid", valid, 1'b0);
            check("rd_onehot", ($countones(rd_en) <= 1), 1'b1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            af = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < EN; i++) hold[i] = ($urandom_range(0, 15) == 0);
        end
    end

    // Order model: chunk -> engine -> line, one command per epoch
    task automatic load(input int dim, input int nep, input logic [63:0] base);
        int chunks;
        int lines;
        logic [511:0] d;
        chunks = (dim + EN*64 - 1) / (EN*64);
        lines  = chunks * EN * LPB;
        for (int e = 0; e < nep; e++) begin
`ifdef X_WB_EPOCH_HISTORY_EN
            ecmd_a.push_back(base + 64'(e) * 64'(lines) * 64);
`else
            ecmd_a.push_back(base);
`endif
            ecmd_l.push_back(32'(lines * 64));
            for (int c = 0; c < chunks; c++)
                for (int g = 0; g < EN; g++)
                    for (int l = 0; l < LPB; l++) begin
                        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
                        fq[g].push_back(d);
                        exp_beats.push_back(d);
                    end
        end
    endtask

    task automatic run(input int dim, input int nep, input logic [63:0] base,
                       input int budget, output int n);
        addr_model = base;
        dimension  = dim;
        numEpochs  = nep;
        tick();
        started = 1'b1;
        tick();
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done", done, 1'b1);
        repeat (4) tick();
        check("beats_left", exp_beats.size(), 0);
        check("cmds_left", ecmd_a.size(), 0);
        started = 1'b0;
        tick();
        tick();
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, "_rd_en"}, rd_en, '0);
        check({tag, "_start"}, start, 1'b0);
        check({tag, "_addr"}, cmd_addr, '0);
        check({tag, "_len"}, cmd_len, '0);
        check({tag, "_data"}, x_data_out, '0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_sc"}, sc, '0);
    endtask

    initial begin
        int n;
        int b0;
        repeat (3) tick();
        zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // single epoch, plain ordering
        beats = 0; starts = 0;
        load(512, 1, 64'h1000);
        check("pin_len512", ecmd_l[0], 32'd2048);
        check("pin_addr512", ecmd_a[0], 64'h1000);
        check("pin_beats512", exp_beats.size(), 32);
        run(512, 1, 64'h1000, 500, n);
        check("t1_beats", beats, 32);
        check("t1_starts", starts, 1);
        check("t1_epoch", sc[31:16], 16'd1);
        check("t1_err", sc[15:12], 4'd0);

        // three epochs under random back-pressure and empty holes
        beats = 0; starts = 0;
        load(1000, 3, 64'h1000);
        check("pin_len1000", ecmd_l[0], 32'd4096);
        check("pin_beats1000", exp_beats.size(), 192);
`ifdef X_WB_EPOCH_HISTORY_EN
        check("pin_addr_e2", ecmd_a[2], 64'h3000);
`else
        check("pin_addr_e2", ecmd_a[2], 64'h1000);
`endif
        rand_en = 1'b1;
        run(1000, 3, 64'h1000, 4000, n);
        rand_en = 1'b0;
        tick();
        af = 1'b0;
        hold = '0;
        tick();
        check("t2_beats", beats, 192);
        check("t2_starts", starts, 3);

        // almost_full held for 20 cycles mid-stream
        beats = 0;
        load(512, 2, 64'h2000);
        fork
            run(512, 2, 64'h2000, 1000, n);
            begin
                int w;
                w = 0;
                while (beats < 10 && w < 500) begin tick(); w++; end
                check("af_reach", beats >= 10, 1'b1);
                af = 1'b1;
                b0 = beats;
                repeat (20) tick();
                check("af_slack", (beats - b0) <= 2, 1'b1);
                af = 1'b0;
            end
        join
        check("t3_beats", beats, 64);

        // fifo3 empty during its turn
        beats = 0;
        hold[3] = 1'b1;
        load(512, 1, 64'h3000);
        fork
            run(512, 1, 64'h3000, 1000, n);
            begin
                int w;
                w = 0;
                while (beats < 12 && w < 500) begin tick(); w++; end
                repeat (10) tick();
                check("stall_beats", beats, 12);
                hold[3] = 1'b0;
            end
        join
        check("t4_beats", beats, 32);

        // dimension zero and zero epochs
        starts = 0;
        run(0, 1, 64'h5000, 20, n);
        check("dim0_fast", n <= 4, 1'b1);
        check("dim0_err", sc[15:12], 4'b0001);
        check("dim0_starts", starts, 0);
        run(512, 0, 64'h5000, 20, n);
        check("nep0_err", sc[15:12], 4'b0000);
        check("nep0_starts", starts, 0);

        // reset in the middle of an epoch
        beats = 0;
        load(512, 1, 64'h1000);
        addr_model = 64'h1000;
        dimension  = 512;
        numEpochs  = 1;
        started    = 1'b1;
        n = 0;
        while (beats < 10 && n < 500) begin tick(); n++; end
        check("mid_reach", beats >= 10, 1'b1);
        rst_n = 1'b0;
        #1;
        zero_outputs("midrst");
        started = 1'b0;
        for (int i = 0; i < EN; i++) fq[i].delete();
        exp_beats.delete();
        ecmd_a.delete();
        ecmd_l.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        beats = 0; starts = 0;
        load(512, 1, 64'h4000);
        run(512, 1, 64'h4000, 500, n);
        check("post_beats", beats, 32);
        check("post_starts", starts, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
